codec_cfg_sequencer: RTL and testbench

CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

---
 rtl/codec_cfg_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer
//   Drives an external I2C byte writer to configure an audio codec. A start
//   pulse plays an 11-entry init table; each transfer is followed by an idle
//   gap. A NACK re-sends the same word up to MAX_RETRY extra times before the
//   sequence aborts. Once the codec is active, headphone volume updates are
//   accepted and written as a two-word left/right pair.
//
// Ports
//   sys_clk    in   sole clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins the init sequence
//   vol_valid  in   volume update request
//   vol_level  in   7-bit headphone volume code
//   vol_ready  out  volume request accepted when high together with vol_valid
//   i2c_req    out  transfer request to the byte writer (registered)
//   i2c_dev    out  7-bit device address (constant DEV_ADDR)
//   i2c_word   out  {reg_addr[6:0], reg_data[8:0]} (registered)
//   i2c_ack    in   one-cycle pulse, transfer completed OK
//   i2c_nack   in   one-cycle pulse, transfer failed
//   busy       out  sequence or volume write in progress
//   done       out  init complete, codec active
//   error      out  init or volume write aborted after exhausted retries
module codec_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         GAP_CYCLES = 500,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        vol_valid,
  input  logic [6:0]  vol_level,
  output logic        vol_ready,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev,
  output logic [15:0] i2c_word,
  input  logic        i2c_ack,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT, GAP, DONE, VOL, ERR
  } state_t;

  localparam int INIT_LEN = 11;
  // The gap counter counts down to zero, so it is loaded with one less than
  // the number of idle cycles wanted.
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW       = (GAP_LOAD < 2) ? 1 : $clog2(GAP_LOAD + 1);
  localparam int RW       = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  // Init table, entry 0 in the least significant 16 bits.
  localparam logic [INIT_LEN*16-1:0] INIT_TABLE = {
    {7'h09, 9'h001}, {7'h08, 9'h000}, {7'h07, 9'h00A}, {7'h06, 9'h000},
    {7'h05, 9'h000}, {7'h04, 9'h012}, {7'h03, 9'h079}, {7'h02, 9'h079},
    {7'h01, 9'h017}, {7'h00, 9'h017}, {7'h0F, 9'h000}
  };

  state_t        state_reg;
  logic          i2c_req_reg;
  logic [15:0]   word_reg;
  logic [3:0]    index_reg;
  logic [RW-1:0] retry_reg;
  logic [GW-1:0] gap_reg;
  logic          vol_mode_reg;   // current sequence is a volume pair
  logic          last_reg;       // word just acknowledged ended its sequence
  logic [6:0]    vol_reg;

  // ROM padded to the full 4-bit index range so every index value is legal.
  logic [15:0] init_rom [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rom
      if (gi < INIT_LEN) begin : g_entry
        assign init_rom[gi] = INIT_TABLE[gi*16 +: 16];
      end else begin : g_pad
        assign init_rom[gi] = 16'h0000;
      end
    end
  endgenerate

  // Volume pair: register 02 first, then register 03, same level for both.
  logic [15:0] vol_word;
  assign vol_word = {(index_reg[0] ? 7'h03 : 7'h02), 2'b00, vol_reg};

  logic last_word;
  assign last_word = vol_mode_reg ? (index_reg == 4'd1)
                                  : (index_reg == 4'(INIT_LEN - 1));

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      i2c_req_reg  <= 1'b0;
      word_reg     <= 16'h0000;
      index_reg    <= 4'd0;
      retry_reg    <= '0;
      gap_reg      <= '0;
      vol_mode_reg <= 1'b0;
      last_reg     <= 1'b0;
      vol_reg      <= 7'd0;
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          // start wins over a coincident volume request in DONE.
          if (start) begin
            index_reg    <= 4'd0;
            retry_reg    <= '0;
            vol_mode_reg <= 1'b0;
            last_reg     <= 1'b0;
            state_reg    <= LOAD;
          end else if (state_reg == DONE && vol_valid) begin
            vol_reg      <= vol_level;
            index_reg    <= 4'd0;
            retry_reg    <= '0;
            vol_mode_reg <= 1'b1;
            last_reg     <= 1'b0;
            state_reg    <= VOL;
          end
        end

        LOAD: begin
          word_reg    <= init_rom[index_reg];
          i2c_req_reg <= 1'b1;
          state_reg   <= REQ;
        end

        VOL: begin
          word_reg    <= vol_word;
          i2c_req_reg <= 1'b1;
          state_reg   <= REQ;
        end

        REQ: begin
          state_reg <= WAIT;
        end

        WAIT: begin
          // NACK is checked first so a simultaneous ACK+NACK counts as NACK.
          if (i2c_nack) begin
            i2c_req_reg <= 1'b0;
            last_reg    <= 1'b0;
            if (retry_reg < RW'(MAX_RETRY)) begin
              retry_reg <= retry_reg + 1'b1;
              gap_reg   <= GW'(GAP_LOAD);
              state_reg <= GAP;
            end else begin
              state_reg <= ERR;
            end
          end else if (i2c_ack) begin
            i2c_req_reg <= 1'b0;
            retry_reg   <= '0;
            index_reg   <= index_reg + 4'd1;
            last_reg    <= last_word;
            gap_reg     <= GW'(GAP_LOAD);
            state_reg   <= GAP;
          end
        end

        GAP: begin
          if (gap_reg == '0) begin
            if (last_reg) begin
              state_reg <= DONE;
            end else if (vol_mode_reg) begin
              state_reg <= VOL;
            end else begin
              state_reg <= LOAD;
            end
          end else begin
            gap_reg <= gap_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign i2c_req   = i2c_req_reg;
  assign i2c_word  = word_reg;
  assign i2c_dev   = DEV_ADDR;
  assign vol_ready = (state_reg == DONE);
  assign done      = (state_reg == DONE);
  assign error     = (state_reg == ERR);
  assign busy      = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer
//   Directed scenarios for codec_cfg_sequencer with a short gap. A responder
//   answers every request 20 cycles after it rises, with NACKs planned per
//   scenario. A negedge process keeps a transaction-level model (phase,
//   words left, retry count, word pointer) and checks the outputs every
//   cycle; scenarios add literal checks on the recorded word stream.
module tb_codec_cfg_sequencer;

  localparam int G  = 8;
  localparam int MR = 3;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        start;
  logic        vol_valid;
  logic [6:0]  vol_level;
  logic        vol_ready;
  logic        i2c_req;
  logic [6:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic        i2c_ack;
  logic        i2c_nack;
  logic        busy;
  logic        done;
  logic        error;

  always #5 sys_clk = ~sys_clk;

  codec_cfg_sequencer #(
    .DEV_ADDR   (7'h1A),
    .GAP_CYCLES (G),
    .MAX_RETRY  (MR)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .start     (start),
    .vol_valid (vol_valid),
    .vol_level (vol_level),
    .vol_ready (vol_ready),
    .i2c_req   (i2c_req),
    .i2c_dev   (i2c_dev),
    .i2c_word  (i2c_word),
    .i2c_ack   (i2c_ack),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register/data pairs of the init table.
  logic [6:0] init_reg  [11] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04,
                                 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
  logic [8:0] init_data [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                                 9'h000, 9'h000, 9'h00A, 9'h000, 9'h001};

  function automatic logic [15:0] model_word(input int mode, input int ptr, input logic [6:0] v);
    if (mode == 0) begin
      if (ptr > 10) return 16'h0000;
      return {init_reg[ptr], init_data[ptr]};
    end
    return {((ptr == 0) ? 7'h02 : 7'h03), 2'b00, v};
  endfunction

  // Responder plan
  int          nack_left = 0;
  int          both_left = 0;
  logic [15:0] nack_word = 16'h0000;

  initial begin
    forever begin
      @(posedge i2c_req);
      repeat (20) @(posedge sys_clk);
      #1;
      if (both_left > 0) begin
        both_left--;
        i2c_ack  = 1'b1;
        i2c_nack = 1'b1;
      end else if (nack_left > 0 && i2c_word == nack_word) begin
        nack_left--;
        i2c_nack = 1'b1;
      end else begin
        i2c_ack = 1'b1;
      end
      @(posedge sys_clk);
      #1;
      i2c_ack  = 1'b0;
      i2c_nack = 1'b0;
    end
  end

  // Model and per-cycle compare
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;
  int          m_phase = M_IDLE;
  int          m_mode  = 0;
  int          m_ptr   = 0;
  int          m_left  = 0;
  int          m_retry = 0;
  int          m_cnt   = 0;
  logic [6:0]  m_vol   = 7'd0;
  bit          prev_req = 1'b0;
  bit          expect_low = 1'b0;
  bit          seq_first = 1'b0;
  int          low_cnt = 0;
  logic [15:0] sent_q [$];

  initial begin
    forever begin
      @(negedge sys_clk);
      if (!reset) begin
        m_phase = M_IDLE; m_cnt = 0; m_retry = 0;
        prev_req = 1'b0; expect_low = 1'b0; low_cnt = 0;
      end else begin
        check("busy",      busy,      m_phase == M_RUN);
        check("done",      done,      m_phase == M_DONE);
        check("error",     error,     m_phase == M_ERR);
        check("vol_ready", vol_ready, m_phase == M_DONE);
        check("i2c_dev",   i2c_dev,   7'h1A);
        if (m_phase != M_RUN) check("req_idle", i2c_req, 1'b0);
        if (expect_low) begin
          check("req_low_after_resp", i2c_req, 1'b0);
          expect_low = 1'b0;
        end
        if (i2c_req) begin
          check("word", i2c_word, model_word(m_mode, m_ptr, m_vol));
          if (!prev_req) begin
            sent_q.push_back(i2c_word);
            if (!seq_first) check("gap_len_ok", low_cnt >= G, 1'b1);
            seq_first = 1'b0;
            low_cnt = 0;
          end
        end else begin
          low_cnt++;
        end
        prev_req = i2c_req;

        // Advance the model across the coming rising edge.
        if (m_phase != M_RUN && start) begin
          m_phase = M_RUN; m_mode = 0; m_ptr = 0; m_left = 11;
          m_retry = 0; m_cnt = 0; seq_first = 1'b1;
        end else if (m_phase == M_DONE && vol_valid) begin
          m_phase = M_RUN; m_mode = 1; m_ptr = 0; m_left = 2;
          m_retry = 0; m_cnt = 0; m_vol = vol_level; seq_first = 1'b1;
        end else if (m_phase == M_RUN) begin
          if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_phase = M_DONE;
          end else if (i2c_req && (i2c_ack || i2c_nack)) begin
            expect_low = 1'b1;
            if (i2c_nack) begin
              if (m_retry < MR) m_retry++;
              else m_phase = M_ERR;
            end else begin
              m_retry = 0;
              m_ptr++;
              m_left--;
              if (m_left == 0) m_cnt = G;
            end
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    #1;
    check({name, "_timeout"}, n < budget, 1'b1);
  endtask

  initial begin
    int n;
    int cnt;
    bit all_same;
    reset = 1'b0; start = 1'b0; vol_valid = 1'b0; vol_level = 7'd0;
    i2c_ack = 1'b0; i2c_nack = 1'b0;

    // Reset state
    #3;
    check("rst_req",       i2c_req,   1'b0);
    check("rst_word",      i2c_word,  16'h0000);
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_error",     error,     1'b0);
    check("rst_vol_ready", vol_ready, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1 check("idle_no_start", busy, 1'b0);

    // Scenario 1: nominal init, volume request during init must be refused
    sent_q.delete();
    pulse_start();
    repeat (40) @(posedge sys_clk);
    #1 vol_valid = 1'b1; vol_level = 7'h11;
    repeat (30) @(posedge sys_clk);
    #1 vol_valid = 1'b0;
    wait_end(3000, "s1");
    check("s1_done",   done,  1'b1);
    check("s1_busy",   busy,  1'b0);
    check("s1_count",  sent_q.size(), 11);
    check("s1_first",  sent_q[0],  16'h1E00);
    check("s1_word5",  sent_q[5],  16'h0812);
    check("s1_last",   sent_q[10], 16'h1201);

    // Scenario 4: volume write from DONE
    sent_q.delete();
    @(posedge sys_clk); #1 vol_valid = 1'b1; vol_level = 7'h50;
    @(posedge sys_clk); #1 vol_valid = 1'b0;
    wait_end(1000, "s4");
    check("s4_done",  done, 1'b1);
    check("s4_count", sent_q.size(), 2);
    check("s4_left",  sent_q[0], 16'h0450);
    check("s4_right", sent_q[1], 16'h0650);

    // Scenario 2: two NACKs on 04:012
    sent_q.delete();
    nack_word = 16'h0812; nack_left = 2;
    pulse_start();
    wait_end(3000, "s2");
    cnt = 0;
    foreach (sent_q[i]) if (sent_q[i] == 16'h0812) cnt++;
    check("s2_word4_sends", cnt, 3);
    check("s2_count", sent_q.size(), 13);
    check("s2_done",  done,  1'b1);
    check("s2_error", error, 1'b0);

    // Scenario 6: ACK and NACK together on word 0
    sent_q.delete();
    both_left = 1;
    pulse_start();
    wait_end(3000, "s6");
    check("s6_first",  sent_q[0], 16'h1E00);
    check("s6_resent", sent_q[1], 16'h1E00);
    check("s6_next",   sent_q[2], 16'h0017);
    check("s6_count",  sent_q.size(), 12);
    check("s6_done",   done, 1'b1);

    // Scenario 3: retry exhaustion on word 0, then clean restart
    sent_q.delete();
    nack_word = 16'h1E00; nack_left = 100;
    pulse_start();
    wait_end(1000, "s3");
    check("s3_error",    error,   1'b1);
    check("s3_done",     done,    1'b0);
    check("s3_req",      i2c_req, 1'b0);
    check("s3_attempts", sent_q.size(), 4);
    all_same = 1'b1;
    foreach (sent_q[i]) if (sent_q[i] != 16'h1E00) all_same = 1'b0;
    check("s3_all_word0", all_same, 1'b1);
    nack_left = 0;
    repeat (5) @(posedge sys_clk);
    sent_q.delete();
    pulse_start();
    wait_end(3000, "s3r");
    check("s3r_done",  done, 1'b1);
    check("s3r_first", sent_q[0], 16'h1E00);
    check("s3r_count", sent_q.size(), 11);

    // Scenario 5: reset while waiting for a response
    pulse_start();
    n = 0;
    while (!i2c_req && n < 50) begin
      @(posedge sys_clk);
      n++;
    end
    check("s5_req_seen", i2c_req, 1'b1);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    #2 reset = 1'b0;
    #1;
    check("s5_req_async",  i2c_req,  1'b0);
    check("s5_busy_async", busy,     1'b0);
    check("s5_word_async", i2c_word, 16'h0000);
    check("s5_done_async", done,     1'b0);
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1;
    check("s5_late_ack_busy",  busy,    1'b0);
    check("s5_late_ack_req",   i2c_req, 1'b0);
    check("s5_late_ack_done",  done,    1'b0);
    check("s5_late_ack_error", error,   1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
